// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one active-low column per scan tick, debounces a single key
// press/release, and presents the key code through a valid/ready register with sticky overflow.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4,
  localparam int CW          = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            overflow,
  output logic            held
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DVW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DVW-1:0] DIV_LAST = DVW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  COL_LAST = IW'(COLS - 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESS    = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [ROWS-1:0] sync1, sync2, rs;
  logic [DVW-1:0]  div_cnt;
  logic            tick;
  logic [1:0]      state, state_nxt;
  logic [IW-1:0]   col_idx, col_idx_nxt, col_adv;
  logic [RW-1:0]   row_idx, row_idx_nxt, hit_idx;
  logic [DBW-1:0]  cnt, cnt_nxt;
  logic [ROWS-1:0] cap_row;
  logic            offer;
  logic [CW-1:0]   offer_code;

  assign rs         = ~sync2;
  assign tick       = (div_cnt == DIV_LAST);
  assign col_adv    = (col_idx == COL_LAST) ? '0 : col_idx + IW'(1);
  assign cap_row    = ROWS'(1) << row_idx;
  assign offer_code = CW'(int'(row_idx) * COLS + int'(col_idx));
  assign held       = (state == S_PRESS) || (state == S_RELEASE);

  always_comb begin
    hit_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rs[r]) hit_idx = RW'(r);
    end
  end

  // Multi-row patterns (ghosting or several keys) are never captured; the scan just moves on.
  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    row_idx_nxt = row_idx;
    cnt_nxt     = cnt;
    offer       = 1'b0;
    case (state)
      S_SCAN: begin
        if (tick) begin
          if ($onehot(rs)) begin
            row_idx_nxt = hit_idx;
            cnt_nxt     = '0;
            state_nxt   = S_DEBOUNCE;
          end else begin
            col_idx_nxt = col_adv;
          end
        end
      end
      S_DEBOUNCE: begin
        if (tick) begin
          if (rs == cap_row) begin
            if (cnt == DB_LAST) begin
              cnt_nxt   = '0;
              state_nxt = S_PRESS;
            end else begin
              cnt_nxt = cnt + DBW'(1);
            end
          end else begin
            state_nxt   = S_SCAN;
            col_idx_nxt = col_adv;
          end
        end
      end
      S_PRESS: begin
        offer     = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (tick) begin
          if (rs == '0) begin
            if (cnt == DB_LAST) begin
              cnt_nxt     = '0;
              state_nxt   = S_SCAN;
              col_idx_nxt = col_adv;
            end else begin
              cnt_nxt = cnt + DBW'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      div_cnt <= '0;
      state   <= S_SCAN;
      col_idx <= '0;
      row_idx <= '0;
      cnt     <= '0;
      col     <= ~COLS'(1);
    end else begin
      sync1   <= row;
      sync2   <= sync1;
      div_cnt <= tick ? '0 : div_cnt + DVW'(1);
      state   <= state_nxt;
      col_idx <= col_idx_nxt;
      row_idx <= row_idx_nxt;
      cnt     <= cnt_nxt;
      col     <= ~(COLS'(1) << col_idx_nxt);
    end
  end

  // An offer that cannot be accepted is dropped; the pending code is kept and overflow sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (offer) begin
      if (!key_valid || key_ready) begin
        key_code  <= offer_code;
        key_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of keypad row lines; legal range 1..8.
REQ-002 Parameter COLS, default 4: number of keypad column lines; legal range 1..8.
REQ-003 Parameter SCAN_DIV, default 100000: clk cycles per scan tick; minimum 2.
REQ-004 Parameter DEBOUNCE_CNT, default 4: consecutive stable scan ticks required for press and for release; minimum 1.
REQ-005 Localparam CW = max(1, clog2(ROWS*COLS)): width of the key code.
REQ-006 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port row, input, ROWS: raw keypad rows, active-low, asynchronous to clk.
REQ-009 Port col, output, COLS: column drive, active-low, exactly one bit low at all times.
REQ-010 Port key_code, output, CW: debounced key index, row_idx*COLS + col_idx.
REQ-011 Port key_valid, output, 1: key_code holds an unconsumed event.
REQ-012 Port key_ready, input, 1: consumer accepts the event when key_valid && key_ready.
REQ-013 Port overflow, output, 1: sticky flag; an event was dropped.
REQ-014 Port held, output, 1: a debounced key is currently held down.

Function
REQ-015 row shall pass through a 2-flop synchronizer and then be inverted, giving active-high rs; 2-cycle input latency.
REQ-016 The divider counter shall count 0..SCAN_DIV-1 and wrap; tick is asserted for one clk cycle when the count equals SCAN_DIV-1.
REQ-017 The FSM has states SCAN, DEBOUNCE, PRESS, RELEASE; all transitions other than PRESS->RELEASE occur only on tick.
REQ-018 SCAN, on tick: if rs is one-hot, capture row_idx and the current col_idx, clear the stability count, and go to DEBOUNCE; otherwise advance col_idx, wrapping COLS-1 to 0.
REQ-019 SCAN, on tick with rs having 2 or more bits set (ghost or multi-key): treat as no key and advance col_idx.
REQ-020 DEBOUNCE, on tick: if rs equals the captured one-hot row, increment the count; when the count reaches DEBOUNCE_CNT, go to PRESS.
REQ-021 DEBOUNCE, on tick with rs differing from the captured row: abort to SCAN, advance col_idx, emit no event.
REQ-022 col_idx is frozen in DEBOUNCE, PRESS and RELEASE.
REQ-023 PRESS lasts one clk cycle, offers the event to the output register, then goes to RELEASE.
REQ-024 RELEASE, on tick: rs == 0 increments the release count, and rs != 0 clears it; at DEBOUNCE_CNT, go to SCAN and advance col_idx.
REQ-025 held = 1 in PRESS and RELEASE, 0 otherwise.
REQ-026 Output register, on offer with key_valid == 0: load key_code and set key_valid the next cycle.
REQ-027 Offer with key_valid && key_ready in the same cycle: load the new code and keep key_valid = 1.
REQ-028 Offer with key_valid && !key_ready: keep the old code and set overflow = 1.
REQ-029 No offer, with key_valid && key_ready: clear key_valid the next cycle; key_code holds its last value.
REQ-030 overflow shall clear only on rst.
REQ-031 col = ~(1 << col_idx), registered.

Reset
REQ-032 rst shall force, on the next edge: state SCAN, col_idx 0, col = {COLS-1{1}},0, divider 0, both counts 0, key_code 0, key_valid 0, overflow 0, held 0, synchronizer flops 0.
REQ-033 rst asserted mid-DEBOUNCE or mid-RELEASE shall discard the in-progress key; no event is emitted after reset.
REQ-034 rst has priority over all other activity, including an offer or handshake in the same cycle.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-035 Reset: after reset release -> col=4'b1110, key_valid=0, overflow=0, held=0; col steps 1101, 1011, 0111, 1110 every 4 clk cycles.
REQ-036 Clean press: row 2 pulled low while col1 is low, held 20 ticks -> one event with key_code=9 and held=1; after release plus 3 idle ticks, scanning resumes at col2.
REQ-037 Bounce: row low for 2 ticks, then high -> no key_valid; FSM returns to SCAN; col advances.
REQ-038 Backpressure: key_ready=0, keys 5 then 6 pressed and released -> key_code stays 5, key_valid=1, overflow=1; key_ready=1 for 1 cycle -> key_valid=0.
REQ-039 Ghosting: rows 0 and 3 both low on col0 -> no event; col advances to 1101.
REQ-040 Reset mid-DEBOUNCE: rst pulsed at count 2 -> all outputs at reset values; key_valid stays 0 until a full new press completes.
